// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the board-level reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOST_CNT_W = 8;

  // Status LED bit positions
  localparam int LED_HB       = 0;
  localparam int LED_LOCK     = 1;
  localparam int LED_STATE_LO = 2;
  localparam int LED_STATE_HI = 3;
  localparam int LED_LOST_LO  = 4;
  localparam int LED_LOST_HI  = 7;

  // Saturating increment for the lock-loss counter
  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Board-side signals of the reset sequencer: PLL lock and button in,
// domain resets and status out.
interface rst_seq_ctrl_if #(
  parameter int N_DOM = 3
);
  logic             i_locked;
  logic             i_sw_rst;
  logic [N_DOM-1:0] o_rst;
  logic [1:0]       o_state;
  logic [7:0]       o_lost_cnt;
  logic [7:0]       o_led;

  modport master (
    output i_locked, i_sw_rst,
    input  o_rst, o_state, o_lost_cnt, o_led
  );

  modport slave (
    input  i_locked, i_sw_rst,
    output o_rst, o_state, o_lost_cnt, o_led
  );
endinterface

// File: rtl/rst_seq_sync_deb.sv
// Two-flop synchroniser with an optional debouncer. With debouncing on,
// the level only follows the synchronised input after DEB_CYC consecutive
// samples that differ from the current level; rise_o pulses for one cycle
// when the debounced level goes high.
module rst_seq_sync_deb #(
  parameter bit DEB_EN  = 1'b1,
  parameter int DEB_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q;

  // metastability filter on the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
    end
  end

  if (DEB_EN) begin : g_deb
    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic             deb_q, deb_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // count samples disagreeing with the held level; any agreeing sample restarts
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (s2_q != deb_q) begin
        if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
          deb_d = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      rise_d = deb_d & ~deb_q;
    end

    // debounce state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_q  <= 1'b0;
        rise_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        deb_q  <= deb_d;
        rise_q <= rise_d;
        cnt_q  <= cnt_d;
      end
    end

    assign level_o = deb_q;
    assign rise_o  = rise_q;
  end else begin : g_nodeb
    assign level_o = s2_q;
    assign rise_o  = 1'b0;
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Board-level reset sequencer: qualifies PLL lock, holds all domains in
// reset, releases them one at a time, and re-asserts on lock loss or a
// debounced soft-reset press.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   WAIT_LOCK | all domains in reset, filtering synced lock
//   HOLD      | lock qualified, all domains held for HOLD_CYC cycles
//   RELEASE   | domains released in index order every STAGGER_CYC
//   RUN       | all domains out of reset, heartbeat running
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int LOCK_FILT   = 4,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 8,
  parameter int DEB_CYC     = 1000,
  parameter int HB_DIV      = 24
) (
  input  logic          clk_p,
  input  logic          rst_top,
  rst_seq_ctrl_if.slave bus
);

  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int STAG_W = $clog2(STAGGER_CYC + 1);
  localparam int IDX_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  logic lock_s;
  logic sw_rise;
  logic lock_rise_unused;
  logic sw_level_unused;

  rst_seq_sync_deb #(.DEB_EN(1'b0), .DEB_CYC(2)) u_lock_sync (
    .clk     (clk_p),
    .rst_n   (rst_top),
    .async_i (bus.i_locked),
    .level_o (lock_s),
    .rise_o  (lock_rise_unused)
  );

  rst_seq_sync_deb #(.DEB_EN(1'b1), .DEB_CYC(DEB_CYC)) u_sw_deb (
    .clk     (clk_p),
    .rst_n   (rst_top),
    .async_i (bus.i_sw_rst),
    .level_o (sw_level_unused),
    .rise_o  (sw_rise)
  );

  state_t                state_q, state_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [STAG_W-1:0]     stag_q, stag_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_DOM-1:0]      rst_q, rst_d;
  logic [LOST_CNT_W-1:0] lost_q, lost_d;
  logic [HB_DIV-1:0]     hb_cnt_q, hb_cnt_d;
  logic                  hb_q, hb_d;
  logic [7:0]            led;

  // next-state, counters and per-domain reset; lock loss outranks the button
  always_comb begin
    state_d  = state_q;
    filt_d   = '0;
    hold_d   = '0;
    stag_d   = '0;
    idx_d    = '0;
    rst_d    = rst_q;
    lost_d   = lost_q;
    hb_cnt_d = '0;
    hb_d     = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        rst_d = '1;
        if (lock_s) begin
          if (filt_q == FILT_W'(LOCK_FILT - 1)) state_d = HOLD;
          else                                  filt_d  = filt_q + 1'b1;
        end
      end
      HOLD: begin
        rst_d = '1;
        if (hold_q == HOLD_W'(HOLD_CYC - 1)) state_d = RELEASE;
        else                                 hold_d  = hold_q + 1'b1;
      end
      RELEASE: begin
        if (stag_q == STAG_W'(STAGGER_CYC - 1)) begin
          for (int k = 0; k < N_DOM; k++) begin
            if (IDX_W'(k) == idx_q) rst_d[k] = 1'b0;
          end
          if (idx_q == IDX_W'(N_DOM - 1)) state_d = RUN;
          else                            idx_d   = idx_q + 1'b1;
        end else begin
          stag_d = stag_q + 1'b1;
          idx_d  = idx_q;
        end
      end
      default: begin
        rst_d = '0;
      end
    endcase

    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
      rst_d   = '1;
      lost_d  = sat_inc(lost_q);
      filt_d  = '0;
      hold_d  = '0;
      stag_d  = '0;
      idx_d   = '0;
    end else if ((state_q == RELEASE || state_q == RUN) && sw_rise) begin
      state_d = HOLD;
      rst_d   = '1;
      filt_d  = '0;
      hold_d  = '0;
      stag_d  = '0;
      idx_d   = '0;
    end

    if (state_q == RUN && state_d == RUN) begin
      hb_cnt_d = hb_cnt_q + 1'b1;
      hb_d     = (&hb_cnt_q) ? ~hb_q : hb_q;
    end
  end

  // state and counter registers
  always_ff @(posedge clk_p or negedge rst_top) begin
    if (!rst_top) begin
      state_q  <= WAIT_LOCK;
      filt_q   <= '0;
      hold_q   <= '0;
      stag_q   <= '0;
      idx_q    <= '0;
      rst_q    <= '1;
      lost_q   <= '0;
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      hold_q   <= hold_d;
      stag_q   <= stag_d;
      idx_q    <= idx_d;
      rst_q    <= rst_d;
      lost_q   <= lost_d;
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  // status LED assembly
  always_comb begin
    led                              = '0;
    led[LED_HB]                      = hb_q;
    led[LED_LOCK]                    = lock_s;
    led[LED_STATE_HI:LED_STATE_LO]   = state_q;
    led[LED_LOST_HI:LED_LOST_LO]     = lost_q[3:0];
  end

  assign bus.o_rst      = rst_q;
  assign bus.o_state    = state_q;
  assign bus.o_lost_cnt = lost_q;
  assign bus.o_led      = led;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed/randomised bench for rst_seq_ctrl. Expectations come from a
// timeline model: outputs as a function of cycles since HOLD entry.
module tb_rst_seq_ctrl;

  localparam int N_DOM = 3;
  localparam int LF    = 4;
  localparam int HC    = 16;
  localparam int SC    = 8;
  localparam int DEB   = 1000;
  localparam int HBD   = 4;
  localparam int RUN_N = HC + N_DOM * SC;

  logic clk_p = 1'b0;
  logic rst_top;

  rst_seq_ctrl_if #(.N_DOM(N_DOM)) bus ();

  rst_seq_ctrl #(
    .N_DOM(N_DOM), .LOCK_FILT(LF), .HOLD_CYC(HC),
    .STAGGER_CYC(SC), .DEB_CYC(DEB), .HB_DIV(HBD)
  ) dut (
    .clk_p   (clk_p),
    .rst_top (rst_top),
    .bus     (bus)
  );

  always #5 clk_p = ~clk_p;

  int n_cmp = 0;
  int n_err = 0;
  int exp_lost = 0;
  int n_cur = 0;
  logic [1:0] sh = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // outputs n edges after HOLD entry (n = 0 is the entry edge)
  function automatic void seq_exp(input int n, output logic [1:0] st,
                                  output logic [N_DOM-1:0] r, output logic hb);
    int rel;
    hb = 1'b0;
    r  = '1;
    if (n < HC) begin
      st = 2'd1;
    end else begin
      rel = (n - HC) / SC;
      if (rel >= N_DOM) begin
        st = 2'd3;
        r  = '0;
        hb = (((n - RUN_N) >> HBD) % 2) == 1;
      end else begin
        st = 2'd2;
        for (int k = 0; k < rel; k++) r[k] = 1'b0;
      end
    end
  endfunction

  task automatic chk_all(input string tag, input logic [1:0] st,
                         input logic [N_DOM-1:0] r, input logic hb);
    logic [7:0] lost_e;
    logic [7:0] led_e;
    lost_e = 8'(exp_lost);
    led_e  = {lost_e[3:0], st, sh[1], hb};
    chk({tag, ".state"}, 32'(bus.o_state), 32'(st));
    chk({tag, ".rst"},   32'(bus.o_rst), 32'(r));
    chk({tag, ".lost"},  32'(bus.o_lost_cnt), 32'(lost_e));
    chk({tag, ".led"},   32'(bus.o_led), 32'(led_e));
  endtask

  task automatic step();
    @(posedge clk_p);
    sh = {sh[0], bus.i_locked};
    #1;
  endtask

  task automatic wait_n(input int cnt, input string tag);
    for (int i = 0; i < cnt; i++) begin
      step();
      chk_all(tag, 2'd0, '1, 1'b0);
    end
  endtask

  task automatic run_seq(input int a, input int b, input string tag);
    logic [1:0] st;
    logic [N_DOM-1:0] r;
    logic hb;
    for (int n = a; n <= b; n++) begin
      step();
      seq_exp(n, st, r, hb);
      chk_all(tag, st, r, hb);
      n_cur = n;
    end
  endtask

  task automatic relock_to(input int n_end, input string tag);
    bus.i_locked = 1'b1;
    wait_n(LF + 1, {tag, ".filt"});
    run_seq(0, n_end, tag);
  endtask

  task automatic lose_lock(input string tag);
    bus.i_locked = 1'b0;
    run_seq(n_cur + 1, n_cur + 2, {tag, ".pre"});
    step();
    exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
    chk_all(tag, 2'd0, '1, 1'b0);
  endtask

  initial begin
    int total;
    int len;
    int h;

    rst_top      = 1'b0;
    bus.i_locked = 1'b1;
    bus.i_sw_rst = 1'b0;
    repeat (5) @(posedge clk_p);
    #1;
    chk_all("reset", 2'd0, '1, 1'b0);

    // power-up with lock already high
    rst_top = 1'b1;
    sh      = 2'b00;
    wait_n(LF + 1, "pwr.filt");
    run_seq(0, RUN_N + 40, "pwr");

    // lock loss in RUN at a random point, then re-sequence
    run_seq(n_cur + 1, n_cur + 1 + $urandom_range(0, 30), "run1");
    lose_lock("loss_run");
    wait_n($urandom_range(3, 20), "loss_wait");

    // glitchy lock never qualifies
    for (int g = 0; g < 25; g++) begin
      h = (g == 0) ? LF - 1 : $urandom_range(1, LF - 1);
      bus.i_locked = 1'b1;
      wait_n(h, "glitch.hi");
      bus.i_locked = 1'b0;
      wait_n(1, "glitch.lo");
    end
    wait_n(3, "glitch.flush");
    relock_to(RUN_N + 20, "relock1");

    // bouncing button, then long press: exactly one HOLD/RELEASE pass
    total = 0;
    while (total < 500) begin
      len = $urandom_range(1, 20);
      bus.i_sw_rst = ~bus.i_sw_rst;
      run_seq(n_cur + 1, n_cur + len, "bounce");
      total += len;
    end
    bus.i_sw_rst = 1'b0;
    run_seq(n_cur + 1, n_cur + 3, "bounce.end");
    bus.i_sw_rst = 1'b1;
    run_seq(n_cur + 1, n_cur + 2 + DEB, "btn.deb");
    run_seq(0, 5000 - DEB - 3, "btn.seq");
    bus.i_sw_rst = 1'b0;
    run_seq(n_cur + 1, n_cur + DEB + 20, "btn.rel");

    // button press while waiting for lock is ignored
    lose_lock("loss_btn");
    bus.i_sw_rst = 1'b1;
    wait_n(DEB + 20, "wait.btn");
    bus.i_sw_rst = 1'b0;
    wait_n(DEB + 20, "wait.btn_rel");

    // button edge landing in HOLD is ignored
    bus.i_sw_rst = 1'b1;
    wait_n(DEB - LF - 4, "hold.btn");
    relock_to(RUN_N + 20, "hold.btn_seq");
    bus.i_sw_rst = 1'b0;
    run_seq(n_cur + 1, n_cur + DEB + 20, "hold.btn_rel");

    // button edge and lock drop on the same edge: lock loss wins
    bus.i_sw_rst = 1'b1;
    run_seq(n_cur + 1, n_cur + DEB, "prio.deb");
    lose_lock("prio");
    bus.i_sw_rst = 1'b0;
    wait_n(DEB + 10, "prio.rel");

    // drive the loss counter into saturation
    for (int i = 0; i < 260; i++) begin
      relock_to(0, "sat.hold");
      lose_lock("sat");
    end
    chk("sat.final", 32'(bus.o_lost_cnt), 32'd255);

    // async reset while domain 0 is already released
    relock_to(HC + SC + $urandom_range(0, SC - 2), "arst.seq");
    #3;
    rst_top = 1'b0;
    #1;
    exp_lost = 0;
    sh       = 2'b00;
    chk_all("arst", 2'd0, '1, 1'b0);
    repeat (3) @(posedge clk_p);
    #1;
    chk_all("arst.held", 2'd0, '1, 1'b0);
    rst_top = 1'b1;
    relock_to(RUN_N + 40, "arst.reseq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
